apb_slave_mem: RTL and testbench



---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_mem_bank.sv | 38 +++
 rtl/apb_slave_mem.sv | 116 +++++++++++
 tb/tb_apb_slave_mem.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types, widths and the address-decode helper for the APB memory completer.
package apb_pkg;

   localparam int unsigned STRB_W     = 4;
   localparam int unsigned WAIT_CNT_W = 4;
   localparam int unsigned WORD_W     = 8 * STRB_W;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // Operands are zero-extended to 64 bits, so the below-base check replaces any wrap.
   function automatic logic apb_addr_err(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth);
      logic [63:0] offs;
      offs = addr - base;
      return (addr[1:0] != 2'b00) || (addr < base) || ((offs >> 2) >= depth);
   endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Byte-strobed word storage: one write port, one combinational read port, async clear.
module apb_mem_bank
   import apb_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [STRB_W-1:0] strb,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] wword_c;

   // Merge the enabled byte lanes into the currently stored word.
   always_comb begin
      wword_c = mem_q[idx];
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) wword_c[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[idx] <= wword_c;
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer: word memory with byte strobes, fixed wait states and error responses.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           MEM_DEPTH   = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_CYCLES = 0,
   parameter bit                    PRIV_ONLY   = 1'b0
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [STRB_W-1:0]     pstrb,
   input  logic [2:0]            pprot,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   apb_state_e            state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] offset_c;
   logic                  setup_err_c;
   logic                  done_c;
   logic                  we_c;
   logic [DATA_WIDTH-1:0] rdata_c;
   logic                  unused_ok_c;

   assign offset_c    = paddr - BASE_ADDR;
   assign setup_err_c = apb_addr_err(64'(paddr), 64'(BASE_ADDR), 64'(MEM_DEPTH))
                        | (PRIV_ONLY & ~pprot[0]);
   assign unused_ok_c = ^{pprot[2:1], offset_c[ADDR_WIDTH-1:IDX_W+2], offset_c[1:0]};

   // Next state: address/control are latched only at setup; data/strobes at completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      err_d   = err_q;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
               idx_d   = offset_c[IDX_W+1:2];
               write_d = pwrite;
               err_d   = setup_err_c;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - WAIT_CNT_W'(1);
               end else begin
                  done_c  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         err_q   <= err_d;
      end
   end

   assign we_c = done_c & write_q & ~err_q;

   apb_mem_bank #(
      .DEPTH (MEM_DEPTH),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk   (pclk),
      .rst_n (presetn),
      .we    (we_c),
      .idx   (idx_q),
      .strb  (pstrb),
      .wdata (pwdata),
      .rdata (rdata_c)
   );

   // Response is visible only in the completion cycle.
   assign pready  = done_c;
   assign pslverr = done_c & err_q;
   assign prdata  = (done_c & ~err_q & ~write_q) ? rdata_c : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three configurations driven by directed and random APB transfers.
module tb_apb_slave_mem;

   localparam int NI = 3;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        psel    [NI];
   logic        penable [NI];
   logic        pwrite  [NI];
   logic [3:0]  pstrb   [NI];
   logic [2:0]  pprot   [NI];
   logic [31:0] paddr   [NI];
   logic [31:0] pwdata  [NI];
   logic [31:0] prdata  [NI];
   logic        pready  [NI];
   logic        pslverr [NI];

   logic        exp_rdy [NI];
   logic        exp_err [NI];
   logic [31:0] exp_rd  [NI];
   logic [31:0] mem_m   [NI][256];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   apb_slave_mem #(.WAIT_CYCLES(0)) u0 (
      .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
      .pstrb(pstrb[0]), .pprot(pprot[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

   apb_slave_mem #(.WAIT_CYCLES(3)) u1 (
      .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
      .pstrb(pstrb[1]), .pprot(pprot[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

   apb_slave_mem #(.WAIT_CYCLES(2), .PRIV_ONLY(1'b1), .MEM_DEPTH(64), .BASE_ADDR(32'h0000_0100)) u2 (
      .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
      .pstrb(pstrb[2]), .pprot(pprot[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
      .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

   function automatic int unsigned wait_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 2;
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 2) ? 32'h0000_0100 : 32'h0;
   endfunction

   function automatic int unsigned depth_of(input int k);
      return (k == 2) ? 64 : 256;
   endfunction

   function automatic bit model_err(input int k, input logic [31:0] a, input logic [2:0] p);
      if (a[1:0] != 2'b00) return 1'b1;
      if (a < base_of(k)) return 1'b1;
      if (((a - base_of(k)) / 4) >= depth_of(k)) return 1'b1;
      if (k == 2 && !p[0]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: each instance's outputs against what the model says they must be.
   always @(negedge pclk) begin
      for (int k = 0; k < NI; k++) begin
         check($sformatf("pready%0d", k),  32'(pready[k]),  32'(exp_rdy[k]));
         check($sformatf("pslverr%0d", k), 32'(pslverr[k]), 32'(exp_err[k]));
         check($sformatf("prdata%0d", k),  prdata[k],       exp_rd[k]);
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_idle(input int k);
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
      exp_rdy[k] = 1'b0;
      exp_err[k] = 1'b0;
      exp_rd[k]  = '0;
   endtask

   task automatic idle(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         set_idle(k);
         @(negedge pclk);
      end
   endtask

   task automatic scramble_ctl(input int k);
      paddr[k]  = $urandom;
      pwrite[k] = 1'($urandom);
      pprot[k]  = 3'($urandom);
      pwdata[k] = $urandom;
      pstrb[k]  = 4'($urandom);
   endtask

   // One full transfer; lat is the cycle index (setup=1) where pready was first seen.
   task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       output logic [31:0] rd, output logic sl, output int lat);
      bit e;
      int idx;
      e   = model_err(k, a, p);
      idx = e ? 0 : int'((a - base_of(k)) / 4);
      lat = 0;
      rd  = '0;
      sl  = 1'b0;
      tick();
      scramble_ctl(k);
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pprot[k] = p;
      exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
      @(negedge pclk);
      if (pready[k] && lat == 0) lat = 1;
      for (int j = 0; j < int'(wait_of(k)); j++) begin
         tick();
         scramble_ctl(k);
         penable[k] = 1'b1;
         @(negedge pclk);
         if (pready[k] && lat == 0) lat = j + 2;
      end
      tick();
      scramble_ctl(k);
      penable[k] = 1'b1; pwdata[k] = d; pstrb[k] = s;
      exp_rdy[k] = 1'b1;
      exp_err[k] = e;
      exp_rd[k]  = (e || wr) ? 32'h0 : mem_m[k][idx];
      @(negedge pclk);
      if (pready[k] && lat == 0) lat = int'(wait_of(k)) + 2;
      rd = prdata[k];
      sl = pslverr[k];
      if (!e && wr) begin
         for (int b = 0; b < 4; b++) if (s[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   // Setup, m stalled access cycles, then psel drops: nothing may complete.
   task automatic xfer_abort(input int k, input logic [31:0] a, input int m);
      tick();
      scramble_ctl(k);
      psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = 1'b1; paddr[k] = a; pprot[k] = 3'b001;
      exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
      @(negedge pclk);
      for (int j = 0; j < m; j++) begin
         tick();
         scramble_ctl(k);
         penable[k] = 1'b1; pstrb[k] = 4'hF;
         @(negedge pclk);
      end
      tick();
      set_idle(k);
      pstrb[k] = 4'hF;
      @(negedge pclk);
   endtask

   task automatic clear_model();
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 256; i++) mem_m[k][i] = '0;
   endtask

   initial begin
      logic [31:0] rd, a;
      logic        sl;
      int          lat, r, m;

      presetn = 1'b0;
      for (int k = 0; k < NI; k++) begin
         set_idle(k);
         scramble_ctl(k);
      end
      clear_model();
      tick();
      tick();
      presetn = 1'b1;

      // Basic read, strobed writes and latency.
      xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("rd04_data", rd, 32'h0);
      check("rd04_lat", 32'(lat), 32'd2);
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 3'b001, rd, sl, lat);
      xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 3'b001, rd, sl, lat);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("rd10_merge", rd, 32'hDE22_BE44);
      idle(0, 1);

      // Wait states and back-to-back read after write.
      xfer(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 3'b001, rd, sl, lat);
      check("wr20_lat", 32'(lat), 32'd5);
      xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("rd20_b2b", rd, 32'hCAFE_F00D);
      check("rd20_lat", 32'(lat), 32'd5);
      idle(1, 1);

      // Error responses.
      xfer(0, 1'b0, 32'h402, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("unaligned_err", 32'(sl), 32'd1);
      check("unaligned_rd", rd, 32'h0);
      xfer(0, 1'b1, 32'h000, 32'h5A5A_5A5A, 4'hF, 3'b001, rd, sl, lat);
      xfer(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, sl, lat);
      check("oob_err", 32'(sl), 32'd1);
      xfer(0, 1'b1, 32'h3FC, 32'h0BAD_F00D, 4'hF, 3'b001, rd, sl, lat);
      check("last_word_ok", 32'(sl), 32'd0);
      xfer(0, 1'b0, 32'h000, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("rd000_kept", rd, 32'h5A5A_5A5A);
      idle(0, 1);
      xfer(2, 1'b0, 32'h100, 32'h0, 4'h0, 3'b000, rd, sl, lat);
      check("priv_err", 32'(sl), 32'd1);
      xfer(2, 1'b0, 32'h0FC, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("below_base_err", 32'(sl), 32'd1);
      xfer(2, 1'b0, 32'h100, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("priv_ok", 32'(sl), 32'd0);

      // Abort after one wait cycle leaves memory untouched.
      xfer(2, 1'b1, 32'h130, 32'h1111_1111, 4'hF, 3'b001, rd, sl, lat);
      idle(2, 1);
      xfer_abort(2, 32'h130, 1);
      xfer(2, 1'b0, 32'h130, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("abort_kept", rd, 32'h1111_1111);
      idle(2, 1);

      // Access phase with no setup is ignored.
      for (int i = 0; i < 2; i++) begin
         tick();
         psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h10; pstrb[0] = 4'hF;
         @(negedge pclk);
      end
      idle(0, 1);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("stray_kept", rd, 32'hDE22_BE44);

      // Reset in the completion cycle of a write clears outputs at once and drops the write.
      xfer(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 3'b001, rd, sl, lat);
      tick();
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h40; pprot[0] = 3'b001;
      exp_rdy[0] = 1'b0; exp_err[0] = 1'b0; exp_rd[0] = '0;
      @(negedge pclk);
      tick();
      penable[0] = 1'b1; pwdata[0] = 32'hFFFF_FFFF; pstrb[0] = 4'hF;
      #1;
      check("pre_reset_rdy", 32'(pready[0]), 32'd1);
      presetn = 1'b0;
      for (int k = 0; k < NI; k++) begin
         exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = '0;
      end
      clear_model();
      #1;
      check("rst_rdy", 32'(pready[0]), 32'd0);
      check("rst_err", 32'(pslverr[0]), 32'd0);
      check("rst_rd", prdata[0], 32'h0);
      set_idle(0);
      @(negedge pclk);
      tick();
      presetn = 1'b1;
      @(negedge pclk);
      xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, sl, lat);
      check("rd40_after_rst", rd, 32'h0);
      idle(0, 1);

      // Random transfers on each configuration.
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 19));
            a = base_of(k) + 32'(4 * $urandom_range(0, 15));
            case (r)
               0: a = $urandom;
               1: a = a + 32'($urandom_range(1, 3));
               2: a = base_of(k) + 32'(4 * (depth_of(k) - 1));
               3: a = base_of(k) + 32'(4 * depth_of(k));
               4: a = base_of(k) - 32'd4;
               default: ;
            endcase
            if (r == 5) begin
               m = int'($urandom_range(0, wait_of(k)));
               xfer_abort(k, a, m);
            end else begin
               xfer(k, 1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), rd, sl, lat);
               check("rand_lat", 32'(lat), 32'(wait_of(k) + 2));
            end
            if ($urandom_range(0, 2) == 0) idle(k, int'($urandom_range(1, 2)));
         end
         idle(k, 1);
      end

      idle(0, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
